// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  // Fields kept for the life of one transaction.
  typedef struct packed {
    logic       store;
    logic [2:0] funct3;
    logic [1:0] off;
    logic [4:0] rd;
  } lsu_op_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, load extraction and legality checks for one access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_st,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic       illegal, misalign;
  logic [7:0] lane_b;
  logic [15:0] lane_h;

  always_comb begin
    illegal  = is_store ? (funct3[2] || funct3[1:0] == 2'b11)
                        : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misalign = (funct3[1:0] == 2'b01 && off[0]) ||
               (funct3[1:0] == 2'b10 && off != 2'b00);
    err      = illegal || misalign;
  end

  always_comb begin
    be       = 4'b1111;
    wdata_st = wdata;
    case (funct3[1:0])
      2'b00: begin
        be       = 4'b0001 << off;
        wdata_st = {4{wdata[7:0]}};
      end
      2'b01: begin
        be       = off[1] ? 4'b1100 : 4'b0011;
        wdata_st = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = rdata[7:0];
    case (off)
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      2'd3:    lane_b = rdata[31:24];
      default: ;
    endcase
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   rdata_ext = {{24{lane_b[7]}}, lane_b};
      F3_LH:   rdata_ext = {{16{lane_h[15]}}, lane_h};
      F3_LW:   rdata_ext = rdata;
      F3_LBU:  rdata_ext = {24'd0, lane_b};
      F3_LHU:  rdata_ext = {16'd0, lane_h};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store sequencer: EA calc, memory handshake, response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [11:0] req_imm,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state_q, state_d;
  lsu_op_t       op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        req_ready_q, req_ready_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [1:0]  resp_err_q, resp_err_d;

  logic [31:0] ea;
  logic        a_store, a_err;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic [3:0]  a_be;
  logic [31:0] a_wdata_st, a_rdata_ext;
  logic        timed_out;

  assign ea = req_base + {{20{req_imm[11]}}, req_imm};

  // In IDLE the aligner checks the incoming op; afterwards it serves the latched one.
  assign a_store = (state_q == S_IDLE) ? req_store  : op_q.store;
  assign a_f3    = (state_q == S_IDLE) ? req_funct3 : op_q.funct3;
  assign a_off   = (state_q == S_IDLE) ? ea[1:0]    : op_q.off;

  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  lsu_align u_align (
    .is_store  (a_store),
    .funct3    (a_f3),
    .off       (a_off),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (a_be),
    .wdata_st  (a_wdata_st),
    .rdata_ext (a_rdata_ext),
    .err       (a_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = a_err ? S_RESP : S_REQ;
      S_REQ:   if (mem_gnt) state_d = op_q.store ? S_RESP : S_WAIT;
      S_WAIT:  if (mem_rvalid || timed_out) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the state being entered.
  always_comb begin
    op_d         = op_q;
    cnt_d        = cnt_q;
    req_ready_d  = (state_d == S_IDLE);
    mem_req_d    = (state_d == S_REQ);
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = (state_d == S_RESP);
    resp_rd_d    = '0;
    resp_data_d  = '0;
    resp_err_d   = ERR_OK;
    case (state_q)
      S_IDLE: if (req_valid) begin
        op_d        = '{store: req_store, funct3: req_funct3, off: ea[1:0], rd: req_rd};
        mem_we_d    = req_store;
        mem_addr_d  = {ea[31:2], 2'b00};
        mem_be_d    = a_be;
        mem_wdata_d = req_store ? a_wdata_st : '0;
        if (a_err) resp_err_d = ERR_ALIGN;
      end
      S_REQ: if (mem_gnt) cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid) begin
          resp_rd_d   = op_q.rd;
          resp_data_d = a_rdata_ext;
        end else if (timed_out) begin
          resp_err_d = ERR_BUS;
        end
      end
      default: ;
    endcase
  end

  assign req_ready  = req_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed plus random ops against a byte-level reference model.
module tb_lsu_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_wdata;
  logic [11:0] req_imm;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  err;
    int          acc;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  resp_t exp_q[$];
  mreq_t mem_q[$];
  resp_t re;
  mreq_t me;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rd", 32'(resp_rd), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
  endtask

  // Monitor: responses and memory requests are checked against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("unexp_resp", 32'(resp_valid), 32'd0);
        else begin
          re = exp_q.pop_front();
          chk("resp_rd", 32'(resp_rd), 32'(re.rd));
          chk("resp_data", resp_data, re.data);
          chk("resp_err", 32'(resp_err), 32'(re.err));
          chk("resp_latency", 32'(cyc - re.acc + 1), 32'(re.lat));
        end
      end
      if (mem_req) begin
        if (mem_q.size() == 0) chk("unexp_mem_req", 32'(mem_req), 32'd0);
        else begin
          me = mem_q[0];
          chk("mem_addr", mem_addr, me.addr);
          chk("mem_we", 32'(mem_we), 32'(me.we));
          chk("mem_be", 32'(mem_be), 32'(me.be));
          if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
          if (mem_gnt) void'(mem_q.pop_front());
        end
      end
    end
  end

  // One full transaction: model, issue, memory-side service, wait for idle.
  // r = cycles from grant to rvalid (1..TO), 0 = rvalid never comes.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [11:0] imm, input logic [31:0] wd, input logic [4:0] rd,
                       input int d, input int r, input logic [31:0] rdat);
    int          simm, size, off, acc, waited, n;
    logic [31:0] ea, swd, ldat;
    logic [3:0]  be;
    logic [63:0] v;
    bit          legal, ok;
    resp_t       e;
    mreq_t       m;

    simm = int'(imm);
    if (imm[11]) simm -= 4096;
    ea    = base + 32'(simm);
    size  = 1 << f3[1:0];
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    ok    = legal && ((ea % 32'(size)) == 0);
    off   = int'(ea % 32'd4);
    be    = 4'(((1 << size) - 1) << off);
    swd   = '0;
    if (size <= 4)
      for (int i = 0; i < 4; i++) swd[8*i +: 8] = wd[8*(i % size) +: 8];
    v = 64'(rdat >> (8*off));
    if (size <= 4) begin
      v = v & ((64'd1 << (8*size)) - 64'd1);
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8*size));
    end
    ldat = v[31:0];

    if (!ok)        e = '{5'd0, 32'd0, 2'd1, 0, 1};
    else if (st)    e = '{5'd0, 32'd0, 2'd0, 0, d + 2};
    else if (r == 0) e = '{5'd0, 32'd0, 2'd2, 0, d + 2 + TO};
    else            e = '{rd, ldat, 2'd0, 0, d + 2 + r};
    m = '{ea & ~32'h3, st, be, swd};

    waited = 0;
    while (!req_ready && waited < 50) begin step(); waited++; end
    chk("ready_before_issue", 32'(req_ready), 32'd1);

    req_store = st; req_funct3 = f3; req_base = base; req_imm = imm;
    req_wdata = wd; req_rd = rd; req_valid = 1'b1;
    mem_gnt = 1'($urandom % 2); mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom;
    step();
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    acc = cyc;
    e.acc = acc;
    exp_q.push_back(e);
    if (ok) mem_q.push_back(m);
    chk("ready_low_after_accept", 32'(req_ready), 32'd0);

    if (ok) begin
      for (int k = 0; k < d; k++) begin
        mem_rvalid = st ? 1'b0 : 1'($urandom % 2);
        mem_rdata  = $urandom;
        step();
      end
      mem_gnt = 1'b1; mem_rvalid = st ? 1'b0 : 1'($urandom % 2);
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!st) begin
        n = (r == 0) ? TO + 2 : r;
        for (int i = 1; i <= n; i++) begin
          mem_rvalid = (r != 0 && i == r);
          mem_rdata  = (i == r) ? rdat : $urandom;
          step();
        end
        mem_rvalid = 1'b0;
      end
    end else begin
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
    end

    waited = 0;
    while (!req_ready && waited < 40) begin step(); waited++; end
    chk("ready_return", 32'(req_ready), 32'd1);
  endtask

  function automatic logic [31:0] sext12(input logic [11:0] i);
    return {{20{i[11]}}, i};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] base, ea;
    logic [11:0] imm;
    int          d, r;

    rst_n = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_base = '0;
    req_imm = '0; req_wdata = '0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    chk_reset_vals();
    rst_n = 1'b1;
    step();

    do_op(1'b0, 3'b000, 32'h1000, 12'hFFF, 32'h0, 5'd7, 0, 1, 32'h80FF_0000);
    do_op(1'b1, 3'b001, 32'h2002, 12'h000, 32'h1234_ABCD, 5'd3, 0, 0, 32'h0);
    do_op(1'b0, 3'b010, 32'h3001, 12'h000, 32'h0, 5'd9, 0, 1, 32'h0);
    do_op(1'b0, 3'b101, 32'h4000, 12'h002, 32'h0, 5'd12, 3, 1, 32'hF00D_0000);
    do_op(1'b0, 3'b010, 32'h6000, 12'h000, 32'h0, 5'd5, 1, 0, 32'h0);
    do_op(1'b0, 3'b100, 32'h7003, 12'h000, 32'h0, 5'd6, 0, TO, 32'h9A00_0000);
    do_op(1'b1, 3'b000, 32'h8003, 12'h000, 32'h0000_00C3, 5'd1, 2, 0, 32'h0);
    do_op(1'b1, 3'b011, 32'h9000, 12'h000, 32'h5555_5555, 5'd2, 0, 0, 32'h0);
    do_op(1'b0, 3'b001, 32'hA002, 12'h7FF, 32'h0, 5'd4, 0, 2, 32'h1234_5678);

    // Reset while waiting for read data: everything clears, late rvalid is ignored.
    while (!req_ready) step();
    req_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h5000; req_imm = '0;
    req_rd = 5'd11; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    mem_q.push_back('{32'h5000, 1'b0, 4'hF, 32'h0});
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    mem_q.delete();
    exp_q.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = (i < 2); mem_gnt = (i < 2); mem_rdata = $urandom;
      step();
      chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
      chk("post_rst_no_req", 32'(mem_req), 32'd0);
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b0;

    for (int n = 0; n < 80; n++) begin
      st   = 1'($urandom % 2);
      f3   = 3'($urandom % 8);
      base = $urandom;
      imm  = 12'($urandom);
      ea   = base + sext12(imm);
      if ($urandom % 4 != 0) base = base - (ea & 32'h3);
      d = int'($urandom % 4);
      r = ($urandom % 10 == 0) ? 0 : (($urandom % 10 == 0) ? TO : int'($urandom_range(1, 3)));
      do_op(st, f3, base, imm, $urandom, 5'($urandom), d, r, $urandom);
    end

    step(); step();
    chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
